// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state encoding,
// the NOP word presented while no instruction is held, and the branch offset helper.
package instruction_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam word_t NOP_WORD         = 32'h0000_0000;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-aligned, sign-extended branch displacement from the 16-bit immediate.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory handshake and the controller-facing fetch outputs.
// master = fetch unit side, slave = memory/controller side.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic       ImemReq;
  word_t      ImemAddr;
  logic       ImemAck;
  word_t      ImemData;
  logic       Advance;
  logic       BranchE;
  logic       BranchNE;
  logic       Zero;
  word_t      Instr;
  logic [5:0] InstHi;
  logic [5:0] InstLo;
  logic       InstValid;
  word_t      PC;
  word_t      PCPlus4;
  logic       FetchErr;

  modport master (
    output ImemReq, ImemAddr, Instr, InstHi, InstLo, InstValid, PC, PCPlus4, FetchErr,
    input  ImemAck, ImemData, Advance, BranchE, BranchNE, Zero
  );

  modport slave (
    input  ImemReq, ImemAddr, Instr, InstHi, InstLo, InstValid, PC, PCPlus4, FetchErr,
    output ImemAck, ImemData, Advance, BranchE, BranchNE, Zero
  );

endinterface

// File: rtl/instruction_fetch_unit_branch_target_calc.sv
// Combinational next-PC logic: sequential PC+4 or a BEQ/BNE target relative to PC+4.
module branch_target_calc
  import instruction_fetch_unit_pkg::*;
(
  input  word_t       pc_i,
  input  logic [15:0] imm_i,
  input  logic        branch_e_i,
  input  logic        branch_ne_i,
  input  logic        zero_i,
  output word_t       pc_plus4_o,
  output word_t       next_pc_o
);

  logic signed [31:0] offset;
  word_t              target;
  logic               taken;

  // Both wrap modulo 2^32; the carry out is deliberately dropped.
  assign pc_plus4_o = pc_i + 32'd4;
  assign offset     = branch_offset(imm_i);
  assign target     = pc_plus4_o + word_t'(offset);

  assign taken      = (branch_e_i & zero_i) | (branch_ne_i & ~zero_i);
  assign next_pc_o  = taken ? target : pc_plus4_o;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register, instruction register and fetch FSM (FETCH -> HOLD -> FETCH, or -> ERROR on
// memory timeout). A held instruction is cleared to NOP whenever it is not valid.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned TMO_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
  localparam bit               TMO_EN  = (TIMEOUT_CYC != 0);

  state_e           state_q, state_d;
  word_t            pc_q, pc_d;
  word_t            instr_q, instr_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] tmo_inc;
  word_t            pc_plus4;
  word_t            next_pc;

  branch_target_calc u_btc (
    .pc_i        (pc_q),
    .imm_i       (instr_q[15:0]),
    .branch_e_i  (bus.BranchE),
    .branch_ne_i (bus.BranchNE),
    .zero_i      (bus.Zero),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      // An ack only counts while the request is actually visible on the bus, so a late
      // ack from before a reset is dropped in the first cycle after reset.
      ST_FETCH: begin
        if (req_q && bus.ImemAck) begin
          instr_d = bus.ImemData;
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = ST_HOLD;
        end else if (req_q && TMO_EN) begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIM) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_HOLD: begin
        if (bus.Advance) begin
          pc_d    = next_pc;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    req_d = (state_d == ST_FETCH);
  end

  assign bus.ImemReq   = req_q;
  assign bus.ImemAddr  = pc_q;
  assign bus.Instr     = instr_q;
  assign bus.InstHi    = instr_q[31:26];
  assign bus.InstLo    = instr_q[5:0];
  assign bus.InstValid = valid_q;
  assign bus.PC        = pc_q;
  assign bus.PCPlus4   = pc_plus4;
  assign bus.FetchErr  = err_q;

endmodule
